data_sram_responder: RTL

Data-side SRAM-like responder that services the load/store requests produced by the core's memory control stage. It accepts `req` with `wr`, `size`, `addr`, `wstrb` and `wdata`, commits writes under the byte strobes into an internal word-addressed array, and returns full 32-bit read words after a fixed latency. It sits in the simulation/SoC memory path as the slave end of the data interface, and stands in for the real data memory during core bring-up and verification.

---
 rtl/dsram_pkg.sv | 19 +
 rtl/data_sram_responder_if.sv | 23 ++
 rtl/dsram_strb_check.sv | 28 ++
 rtl/data_sram_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-side SRAM responder.
package dsram_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dsram_state_e;

  // Access size encodings carried on the size field.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Seed for the optional response-delay LFSR.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side request/response bus between the memory control stage and the responder.
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/dsram_strb_check.sv
// Classifies a request as legal or illegal from its direction, size and byte strobe.
module dsram_strb_check
  import dsram_pkg::*;
(
  input  logic       wr_i,
  input  logic [1:0] size_i,
  input  logic [3:0] wstrb_i,
  output logic       legal_o
);

  // Loads only reject the reserved size; stores also need a strobe shape matching the size.
  always_comb begin
    legal_o = 1'b0;
    if (!wr_i) begin
      legal_o = (size_i != 2'd3);
    end else begin
      case (size_i)
        SIZE_B:  legal_o = wstrb_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
        SIZE_H:  legal_o = wstrb_i inside {4'b0011, 4'b1100};
        // Word size also covers the partial-word SWL/SWR strobe patterns.
        SIZE_W:  legal_o = wstrb_i inside {4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                           4'b1000, 4'b1100, 4'b1110};
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: strobed stores, whole-word loads, fixed response latency.
// Optional feature: define DSRAM_RANDOM_DELAY_EN to add 0-3 LFSR-driven extra wait cycles.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  data_sram_responder_if.slave bus_io
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = $clog2(LATENCY + 4);

  dsram_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [IdxW-1:0] idx;
  logic            legal;
  logic            addr_ok;
  logic            accept;
  logic [1:0]      extra;
  logic            direct_resp;
  logic            unused_addr;

  // Upper address bits alias onto the array; the byte offset is the initiator's concern.
  assign idx         = bus_io.addr[IdxW+1:2];
  assign unused_addr = ^{bus_io.addr[31:IdxW+2], bus_io.addr[1:0]};

  dsram_strb_check u_strb_check (
    .wr_i    (bus_io.wr),
    .size_i  (bus_io.size),
    .wstrb_i (bus_io.wstrb),
    .legal_o (legal)
  );

  assign addr_ok        = rst_ni && (state_q != StWait);
  assign accept         = bus_io.req && addr_ok;
  assign bus_io.addr_ok = addr_ok;
  assign bus_io.data_ok = (state_q == StResp);
  assign bus_io.rdata   = rdata_q;
  assign bus_io.err     = err_q;

`ifdef DSRAM_RANDOM_DELAY_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  // Only a one-cycle latency with no extra delay may skip the WAIT state.
  assign direct_resp = (LATENCY == 1) && (extra == 2'd0);

  // Next-state and countdown; RESP accepts back-to-back exactly like IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (direct_resp) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY + 32'(extra) - 32'd2);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and countdown registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response register captures the addressed word and legality on every accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= mem_q[idx];
      err_q   <= !legal;
    end
  end

  // Array write under byte strobes; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus_io.wr && legal) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_io.wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= bus_io.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
